uart_loader_ctrl: RTL and testbench
===================================

# uart_loader_ctrl

Command sequencer between the UART receiver/transmitter pair and the CPU's memory load port. It assembles byte-serial command frames from `uart_recv`, issues single-word memory writes and reads, and sequences `uart_send` to return ACK, NAK or read data. It also owns `cpu_hold`, which keeps the core stalled while memory is loaded over UART.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: maximum number of `sys_clk` cycles between bytes inside a frame before the frame is aborted.
- `sys_clk` in 1: system clock; the only clock in the block.
- `sys_rst` in 1: asynchronous, active-high reset.
- `uart_done` in 1: one-cycle pulse from `uart_recv` indicating `uart_data` holds a received byte.
- `uart_data` in 8: received byte; valid only while `uart_done` is high.
- `uart_tx_busy` in 1: `uart_send` busy flag.
- `uart_en` out 1: one-cycle transmit request to `uart_send`.
- `uart_din` out 8: byte to transmit; held stable from the `uart_en` pulse until `uart_tx_busy` falls.
- `mem_addr` out 32: word address for the memory access.
- `mem_wdata` out 32: write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 32: read data; sampled when `mem_rvalid` is high.
- `mem_rvalid` in 1: read-data-valid pulse, arriving one or more cycles after `mem_re`.
- `cpu_hold` out 1: high holds the CPU in stall.

## Operation
- Frame opcodes. Multi-byte fields are little-endian (LSB first).
  - `0x00` NOP: ignored; no reply.
  - `0x01` WRITE: 4 address bytes, then 4 data bytes. The block pulses `mem_we` and replies `0x06`.
  - `0x02` READ: 4 address bytes. The block pulses `mem_re`, waits for `mem_rvalid`, then replies with the 4 data bytes LSB first.
  - `0x03` RUN: clears `cpu_hold`; replies `0x06`.
  - `0x04` HALT: sets `cpu_hold`; replies `0x06`.
  - Any other opcode: replies `0x15` (NAK).
- States: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
- IDLE: on `uart_done`, decode the opcode.
  - `0x01` and `0x02` go to GET_ADDR.
  - `0x03`, `0x04` and unknown opcodes load the reply byte and go to TX_LOAD.
  - `0x00` stays in IDLE.
- GET_ADDR and GET_DATA:
  - A 2-bit byte counter shifts each byte into byte lane `cnt` of the address or data register.
  - After the 4th byte, GET_ADDR goes to GET_DATA (WRITE) or MEM_RD (READ); GET_DATA goes to MEM_WR.
- MEM_WR: `mem_we` is high for exactly one cycle, with `mem_addr`/`mem_wdata` valid in that cycle. Next state is TX_LOAD with reply `0x06`.
- MEM_RD: `mem_re` is high for exactly one cycle. Next state is RD_WAIT.
- RD_WAIT: on `mem_rvalid`, latch `mem_rdata`, set the transmit count to 4, go to TX_LOAD. RD_WAIT has no timeout.
- Transmit sequence:
  - TX_LOAD: when `uart_tx_busy` is low, pulse `uart_en` for one cycle and go to TX_WAIT_HI.
  - TX_WAIT_HI: wait for `uart_tx_busy` high, then go to TX_WAIT_LO.
  - TX_WAIT_LO: wait for `uart_tx_busy` low. Then decrement the remaining byte count; go to TX_LOAD if bytes remain, otherwise IDLE.
  - Read replies send lane 0 first, then lanes 1..3.
- Bytes received in any state other than IDLE, GET_ADDR or GET_DATA are dropped and have no side effect.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA, and restarts at each `uart_done`.
  - When the count reaches `TIMEOUT_CYCLES`, the state returns to IDLE.
  - On abort: no reply, no memory strobe, address/data registers keep their partial contents.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.

## Timing
- Reset values: `uart_en`=0, `uart_din`=0x00, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `cpu_hold`=1, state IDLE, counters 0.
- Reset asserted mid-frame or mid-transmit: the block returns to IDLE immediately, and any pending reply is discarded.
- All outputs are registered.
- Write latency: `mem_we` is high in the 2nd cycle after the `uart_done` of the final data byte.
- Read latency: `mem_re` is high in the 2nd cycle after the `uart_done` of the final address byte.
- Reply start: the `uart_en` pulse comes no earlier than 1 cycle after entering TX_LOAD, and only while `uart_tx_busy`=0.
- `cpu_hold` changes in the cycle after the `uart_done` carrying RUN or HALT, before the ACK is sent.
- Simultaneous events:
  - `uart_done` in the same cycle the timeout expires: the byte wins and the counter restarts.
  - `mem_rvalid` in the same cycle as `mem_re`: ignored; only `mem_rvalid` from the cycle after `mem_re` onward is accepted.

## Test plan
- WRITE frame 01 10 00 00 00 EF BE AD DE -> exactly one `mem_we` pulse with `mem_addr`=0x00000010 and `mem_wdata`=0xDEADBEEF; UART reply 0x06.
- READ frame 02 10 00 00 00; memory returns 0x12345678 three cycles after `mem_re` -> one `mem_re` pulse at `mem_addr`=0x00000010; reply bytes 78 56 34 12, in that order.
- Bytes 00 00 00 00, then 03 -> no reply to the four NOPs; `cpu_hold` falls 1→0; single reply 0x06.
- Opcode 0x7F -> reply 0x15; no memory strobe; `cpu_hold` unchanged.
- With `TIMEOUT_CYCLES`=100: send 01 10 00 then idle 150 cycles, then 04 -> no `mem_we`; frame aborted; 04 is decoded as HALT and reply 0x06.
- With `TIMEOUT_CYCLES`=100: send 01 AA BB, assert `sys_rst` for 3 cycles, then send 02 00 00 00 00 -> all outputs at reset values during reset; READ at address 0x00000000 completes normally.

Source files
------------

// File: rtl/uart_loader_ctrl.sv
// UART command sequencer: assembles opcode/address/data frames from the UART receiver,
// drives single-word memory accesses and returns ACK/NAK/read data through the UART sender.
module uart_loader_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_done,
    input  logic [7:0]  uart_data,
    input  logic        uart_tx_busy,
    output logic        uart_en,
    output logic [7:0]  uart_din,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        cpu_hold,
    output logic [3:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_GET_ADDR   = 4'd1,
        S_GET_DATA   = 4'd2,
        S_MEM_WR     = 4'd3,
        S_MEM_RD     = 4'd4,
        S_RD_WAIT    = 4'd5,
        S_TX_LOAD    = 4'd6,
        S_TX_WAIT_HI = 4'd7,
        S_TX_WAIT_LO = 4'd8
    } state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic [TW-1:0] tmo_cnt;
    logic          is_read;
    logic [31:0]   tx_buf;
    logic [2:0]    tx_left;

    assign dbg_state = state;

    // Transmit handshake: uart_en is a one-cycle request issued only while uart_tx_busy is low;
    // the byte on uart_din is held until the sender has raised and then dropped uart_tx_busy.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            tmo_cnt   <= '0;
            is_read   <= 1'b0;
            tx_buf    <= 32'h0;
            tx_left   <= 3'd0;
            uart_en   <= 1'b0;
            uart_din  <= 8'h00;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            uart_en <= 1'b0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (uart_done) begin
                        cnt     <= 2'd0;
                        tmo_cnt <= '0;
                        case (uart_data)
                            8'h00: state <= S_IDLE;
                            8'h01: begin
                                is_read <= 1'b0;
                                state   <= S_GET_ADDR;
                            end
                            8'h02: begin
                                is_read <= 1'b1;
                                state   <= S_GET_ADDR;
                            end
                            8'h03: begin
                                cpu_hold <= 1'b0;
                                tx_buf   <= {24'h0, ACK};
                                tx_left  <= 3'd1;
                                state    <= S_TX_LOAD;
                            end
                            8'h04: begin
                                cpu_hold <= 1'b1;
                                tx_buf   <= {24'h0, ACK};
                                tx_left  <= 3'd1;
                                state    <= S_TX_LOAD;
                            end
                            default: begin
                                tx_buf  <= {24'h0, NAK};
                                tx_left <= 3'd1;
                                state   <= S_TX_LOAD;
                            end
                        endcase
                    end
                end
                S_GET_ADDR, S_GET_DATA: begin
                    // A byte arriving in the expiry cycle wins and restarts the timer.
                    if (uart_done) begin
                        tmo_cnt <= '0;
                        cnt     <= cnt + 2'd1;
                        if (state == S_GET_ADDR) begin
                            mem_addr[{cnt, 3'b000} +: 8] <= uart_data;
                            if (cnt == 2'd3) state <= is_read ? S_MEM_RD : S_GET_DATA;
                        end else begin
                            mem_wdata[{cnt, 3'b000} +: 8] <= uart_data;
                            if (cnt == 2'd3) state <= S_MEM_WR;
                        end
                    end else if (tmo_cnt >= TW'(TIMEOUT_CYCLES)) begin
                        state   <= S_IDLE;
                        cnt     <= 2'd0;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_MEM_WR: begin
                    mem_we  <= 1'b1;
                    tx_buf  <= {24'h0, ACK};
                    tx_left <= 3'd1;
                    state   <= S_TX_LOAD;
                end
                S_MEM_RD: begin
                    mem_re <= 1'b1;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // mem_re is still high in the first cycle here; a coincident rvalid is not ours.
                    if (mem_rvalid && !mem_re) begin
                        tx_buf  <= mem_rdata;
                        tx_left <= 3'd4;
                        state   <= S_TX_LOAD;
                    end
                end
                S_TX_LOAD: begin
                    if (!uart_tx_busy) begin
                        uart_en  <= 1'b1;
                        uart_din <= tx_buf[7:0];
                        state    <= S_TX_WAIT_HI;
                    end
                end
                S_TX_WAIT_HI: begin
                    if (uart_tx_busy) state <= S_TX_WAIT_LO;
                end
                S_TX_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        tx_buf  <= {8'h00, tx_buf[31:8]};
                        tx_left <= tx_left - 3'd1;
                        state   <= (tx_left == 3'd1) ? S_IDLE : S_TX_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Randomized bench for uart_loader_ctrl: frame-level reference model, UART sender and memory
// responders, and a reply scoreboard.
module tb_uart_loader_ctrl;

    localparam int TMO = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_done = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        uart_tx_busy = 1'b0;
    logic        uart_en;
    logic [7:0]  uart_din;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rvalid = 1'b0;
    logic        cpu_hold;
    logic [3:0]  dbg_state;

    uart_loader_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_done    (uart_done),
        .uart_data    (uart_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .cpu_hold     (cpu_hold),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [63:0] exp_we_q[$];
    logic [31:0] exp_re_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];
    logic        ref_hold = 1'b1;
    int          last_done_cyc = 0;
    int          rd_delay_fix = 0;
    logic [7:0]  frm[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
    endfunction

    function automatic logic [31:0] dev_word(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : default_word(a);
    endfunction

    // ---------------- UART sender model ----------------
    initial begin
        logic [7:0] b;
        int n;
        forever begin
            @(negedge sys_clk);
            if (uart_en === 1'b1) begin
                b = uart_din;
                got_q.push_back(b);
                check_eq("en_while_busy", 32'(uart_tx_busy), 32'd0);
                uart_tx_busy = 1'b1;
                n = $urandom_range(3, 6);
                repeat (n) begin
                    @(negedge sys_clk);
                    check_eq("din_stable", 32'(uart_din), 32'(b));
                    check_eq("en_pulse", 32'(uart_en), 32'd0);
                end
                uart_tx_busy = 1'b0;
            end
        end
    end

    // ---------------- memory write monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge sys_clk);
            if (mem_we === 1'b1) begin
                check_eq("we_latency", 32'(cyc), 32'(last_done_cyc + 2));
                if (exp_we_q.size() == 0) begin
                    check_eq("we_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    e = exp_we_q.pop_front();
                    check_eq("we_addr", mem_addr, e[63:32]);
                    check_eq("we_data", mem_wdata, e[31:0]);
                end
                dev_mem[mem_addr] = mem_wdata;
            end
        end
    end

    // ---------------- memory read responder ----------------
    initial begin
        logic [31:0] a;
        int d;
        forever begin
            @(negedge sys_clk);
            if (mem_re === 1'b1) begin
                check_eq("re_latency", 32'(cyc), 32'(last_done_cyc + 2));
                if (exp_re_q.size() == 0) check_eq("re_unexpected", 32'(mem_re), 32'd0);
                else check_eq("re_addr", mem_addr, exp_re_q.pop_front());
                a = mem_addr;
                // Decoy data in the mem_re cycle itself must be ignored.
                if ($urandom_range(0, 1) == 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~dev_word(a);
                end
                @(negedge sys_clk);
                check_eq("re_pulse", 32'(mem_re), 32'd0);
                mem_rvalid = 1'b0;
                d = (rd_delay_fix > 0) ? rd_delay_fix : $urandom_range(1, 4);
                repeat (d - 1) @(negedge sys_clk);
                mem_rvalid = 1'b1;
                mem_rdata  = dev_word(a);
                @(negedge sys_clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        uart_done     = 1'b1;
        uart_data     = b;
        last_done_cyc = cyc;
        @(negedge sys_clk);
        uart_done = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        frm.delete();
        frm.push_back(op);
        if (op == 8'h01 || op == 8'h02)
            for (int i = 0; i < 4; i++) frm.push_back(addr[8*i +: 8]);
        if (op == 8'h01)
            for (int i = 0; i < 4; i++) frm.push_back(data[8*i +: 8]);
    endtask

    // Reference model: what a complete frame must produce.
    task automatic model_frame();
        logic [31:0] a;
        logic [31:0] w;
        case (frm[0])
            8'h00: ;
            8'h01: begin
                a = {frm[4], frm[3], frm[2], frm[1]};
                w = {frm[8], frm[7], frm[6], frm[5]};
                exp_we_q.push_back({a, w});
                ref_mem[a] = w;
                exp_q.push_back(8'h06);
            end
            8'h02: begin
                a = {frm[4], frm[3], frm[2], frm[1]};
                exp_re_q.push_back(a);
                w = ref_word(a);
                for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
            end
            8'h03: begin
                ref_hold = 1'b0;
                exp_q.push_back(8'h06);
            end
            8'h04: begin
                ref_hold = 1'b1;
                exp_q.push_back(8'h06);
            end
            default: exp_q.push_back(8'h15);
        endcase
    endtask

    task automatic run_frame(input bit inject, input int gap);
        int budget;
        bit inj_done;
        int n;
        model_frame();
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i]);
            if (i == 0 && (frm[0] == 8'h03 || frm[0] == 8'h04))
                check_eq("hold_timing", 32'(cpu_hold), 32'(ref_hold));
            if (i != frm.size() - 1)
                repeat ((gap >= 0) ? gap : $urandom_range(0, 5)) @(negedge sys_clk);
        end
        inj_done = !inject;
        budget = 4000;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(negedge sys_clk);
            budget--;
            // A stray byte while the sender is busy must be dropped.
            if (!inj_done && uart_tx_busy) begin
                uart_done = 1'b1;
                uart_data = 8'($urandom_range(0, 255));
                @(negedge sys_clk);
                uart_done = 1'b0;
                inj_done  = 1'b1;
            end
        end
        repeat (30) @(negedge sys_clk);
        n = got_q.size();
        check_eq("reply_cnt", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check_eq("reply_byte", 32'(got_q[i]), 32'(exp_q[i]));
        check_eq("we_missing", 32'(exp_we_q.size()), 32'd0);
        check_eq("re_missing", 32'(exp_re_q.size()), 32'd0);
        check_eq("cpu_hold", 32'(cpu_hold), 32'(ref_hold));
        got_q.delete();
        exp_q.delete();
        exp_we_q.delete();
        exp_re_q.delete();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_uart_en", 32'(uart_en), 32'd0);
        check_eq("rst_uart_din", 32'(uart_din), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_re", 32'(mem_re), 32'd0);
        check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int r;
        repeat (3) begin
            @(negedge sys_clk);
            check_reset_outputs();
        end
        sys_rst = 1'b0;
        ref_hold = 1'b1;

        build_frame(8'h01, 32'h00000010, 32'hDEADBEEF);
        run_frame(1'b0, -1);

        dev_mem[32'h10] = 32'h12345678;
        ref_mem[32'h10] = 32'h12345678;
        rd_delay_fix = 3;
        build_frame(8'h02, 32'h00000010, 32'h0);
        run_frame(1'b0, -1);
        rd_delay_fix = 0;

        repeat (4) begin
            build_frame(8'h00, 32'h0, 32'h0);
            run_frame(1'b0, -1);
        end
        build_frame(8'h03, 32'h0, 32'h0);
        run_frame(1'b0, -1);

        build_frame(8'h7F, 32'h0, 32'h0);
        run_frame(1'b0, -1);

        // Partial WRITE left to time out, then HALT must decode as a fresh opcode.
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (150) @(negedge sys_clk);
        build_frame(8'h04, 32'h0, 32'h0);
        run_frame(1'b0, -1);

        // Long but legal gaps between bytes.
        build_frame(8'h01, 32'h00000024, 32'hCAFEF00D);
        run_frame(1'b0, 90);

        build_frame(8'h03, 32'h0, 32'h0);
        run_frame(1'b0, -1);

        // Reset in the middle of a frame.
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            check_reset_outputs();
        end
        sys_rst = 1'b0;
        ref_hold = 1'b1;
        build_frame(8'h02, 32'h00000000, 32'h0);
        run_frame(1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h10;
                1: a = 32'h14;
                2: a = 32'h20;
                3: a = 32'h24;
                default: a = $urandom;
            endcase
            r = $urandom_range(0, 9);
            case (r)
                0:       build_frame(8'h00, a, 32'h0);
                1, 2, 3: build_frame(8'h01, a, $urandom);
                4, 5, 6: build_frame(8'h02, a, 32'h0);
                7:       build_frame(8'h03, a, 32'h0);
                8:       build_frame(8'h04, a, 32'h0);
                default: build_frame(8'($urandom_range(5, 255)), a, 32'h0);
            endcase
            run_frame(1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
